// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer built around one shared 1-bit full-adder cell.
// Operands shift out LSB first; the sum shifts into an accumulator from the MSB side.

module fulladder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one result bit per cycle, WIDTH cycles
// DONE  | result published for one cycle; start here re-enters RUN
module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT          state;
    stateT          nextState;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] acc;
    logic           carry;
    logic           carryInMsb;
    logic [CW-1:0]  count;
    logic           cellSum;
    logic           cellCout;
    logic           accept;
    logic           lastBit;

    fulladder1 adderCell (
        .a    (opA[0]),
        .b    (opB[0]),
        .cin  (carry),
        .sum  (cellSum),
        .cout (cellCout)
    );

    assign accept  = start && (state == IDLE || state == DONE);
    assign lastBit = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (lastBit) nextState = DONE;
            DONE:    nextState = start ? RUN : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Result registers load on the final RUN edge so they are valid together with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            opA        <= '0;
            opB        <= '0;
            acc        <= '0;
            carry      <= 1'b0;
            carryInMsb <= 1'b0;
            count      <= '0;
            S          <= '0;
            Cout       <= 1'b0;
            V          <= 1'b0;
        end else if (accept) begin
            opA   <= A;
            opB   <= B ^ {WIDTH{sub}};
            carry <= sub;
            count <= '0;
        end else if (state == RUN) begin
            opA   <= opA >> 1;
            opB   <= opB >> 1;
            acc   <= {cellSum, acc[WIDTH-1:1]};
            carry <= cellCout;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 2)) begin
                carryInMsb <= cellCout;
            end
            if (lastBit) begin
                S    <= {cellSum, acc[WIDTH-1:1]};
                Cout <= cellCout;
                V    <= carryInMsb ^ cellCout;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8: vector table plus abort,
// ignored-start and back-to-back sequences.

module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vecT;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         V;

    int checks = 0;
    int errors = 0;

    vecT vecs[9];
    vecT seqOps[3];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .V     (V)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits up to 20 edges for done; n=0 on timeout. runOk drops if S moves or busy falls early.
    task automatic waitDone(output int n, output logic runOk, input logic [W-1:0] heldS);
        n = 0;
        runOk = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
            if (S !== heldS || busy !== 1'b1) runOk = 1'b0;
        end
    endtask

    task automatic runOp(input vecT v, input string tag);
        int n;
        logic ok;
        logic [W-1:0] prevS;
        prevS = S;
        start = 1'b1; A = v.a; B = v.b; sub = v.sub;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        waitDone(n, ok, prevS);
        check({tag, " latency"}, n, 32'd8);
        check({tag, " run_hold"}, 32'(ok), 32'd1);
        check({tag, " S"}, 32'(S), 32'(v.s));
        check({tag, " Cout"}, 32'(Cout), 32'(v.c));
        check({tag, " V"}, 32'(V), 32'(v.v));
        @(posedge clk); #1;
        check({tag, " done_pulse_len"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int nd;
        logic ok;
        logic [W-1:0] gotS;
        logic gotC;
        logic gotV;

        vecs[0] = '{8'h05, 8'h07, 1'b0, 8'h0C, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};

        seqOps[0] = '{8'h05, 8'h07, 1'b0, 8'h0C, 1'b0, 1'b0};
        seqOps[1] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        seqOps[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset S", 32'(S), 32'd0);
        check("reset Cout", 32'(Cout), 32'd0);
        check("reset V", 32'(V), 32'd0);

        for (int i = 0; i < 9; i++) begin
            runOp(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulsed during a run must be ignored.
        start = 1'b1; A = 8'h10; B = 8'h20; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; A = 8'h01; B = 8'h01; sub = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0; gotS = '0; gotC = 1'b1; gotV = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                gotS = S; gotC = Cout; gotV = V;
            end
        end
        check("ignore done_count", nd, 32'd1);
        check("ignore S", 32'(gotS), 32'h30);
        check("ignore Cout", 32'(gotC), 32'd0);
        check("ignore V", 32'(gotV), 32'd0);
        check("ignore idle_after", 32'(busy), 32'd0);

        // Synchronous reset mid-run aborts without a done.
        start = 1'b1; A = 8'hFF; B = 8'hFF; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort S", 32'(S), 32'd0);
        check("abort Cout", 32'(Cout), 32'd0);
        check("abort V", 32'(V), 32'd0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort no_done", nd, 32'd0);
        runOp('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0}, "after_abort");

        // Start held high: accepted in each DONE cycle, done every 9 cycles.
        start = 1'b1; A = seqOps[0].a; B = seqOps[0].b; sub = seqOps[0].sub;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                A = seqOps[i+1].a; B = seqOps[i+1].b; sub = seqOps[i+1].sub;
            end else begin
                start = 1'b0;
            end
            check($sformatf("b2b%0d busy", i), 32'(busy), 32'd1);
            waitDone(n, ok, S);
            check($sformatf("b2b%0d latency", i), n, 32'd8);
            check($sformatf("b2b%0d S", i), 32'(S), 32'(seqOps[i].s));
            check($sformatf("b2b%0d Cout", i), 32'(Cout), 32'(seqOps[i].c));
            check($sformatf("b2b%0d V", i), 32'(V), 32'(seqOps[i].v));
            @(posedge clk); #1;
        end
        check("b2b final idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
